// File: rtl/derr_pkg.sv
// Shared definitions for the chroma error-diffusion load/store paths:
// byte-lane layout of the packed error word and the loader FSM encoding.
package derr_pkg;

   localparam int DERR_W  = 32;
   localparam int DERR_U0 = 0;
   localparam int DERR_U1 = 1;
   localparam int DERR_V0 = 2;
   localparam int DERR_V1 = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } derr_state_e;

endpackage

// File: rtl/load_diffusion_errors.sv
// Loads the top (RAM) and left (running) diffusion errors for one macroblock,
// zeroes them at picture edges and reports them with a fixed-latency done pulse.
module load_diffusion_errors
   import derr_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [AW-1:0]     x,
   input  logic [9:0]        y,
   input  logic [DERR_W-1:0] left_derr,
   input  logic [DERR_W-1:0] top_derr_rd,
   output logic              top_derr_en,
   output logic [AW-1:0]     top_derr_addr,
   output logic [DERR_W-1:0] derr_top,
   output logic [DERR_W-1:0] derr_left,
   output logic              busy,
   output logic              done
);

   // Handshake: start is a one-cycle request honoured only while idle (busy low);
   // done is a one-cycle pulse, and derr_* stay stable until the next done.

   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   derr_state_e       state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [AW-1:0]     x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic [DERR_W-1:0] left_q, left_d;
   logic              en_q, en_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DERR_W-1:0] top_out_q, top_out_d;
   logic [DERR_W-1:0] left_out_q, left_out_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         left_q     <= '0;
         en_q       <= 1'b0;
         addr_q     <= '0;
         top_out_q  <= '0;
         left_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         left_q     <= left_d;
         en_q       <= en_d;
         addr_q     <= addr_d;
         top_out_q  <= top_out_d;
         left_out_q <= left_out_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      left_d     = left_q;
      en_d       = 1'b0;
      addr_d     = addr_q;
      top_out_d  = top_out_q;
      left_out_d = left_out_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d     = x;
               y_d     = y;
               left_d  = left_derr;
               // Row 0 has no top neighbour, so the RAM is left untouched.
               en_d    = (y != '0);
               if (y != '0) addr_d = x;
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               top_out_d  = (y_q != '0) ? top_derr_rd : '0;
               left_out_d = (x_q != '0) ? left_q : '0;
               done_d     = 1'b1;
               state_d    = ST_OUT;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_OUT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign top_derr_en   = en_q;
   assign top_derr_addr = addr_q;
   assign derr_top      = top_out_q;
   assign derr_left     = left_out_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;

endmodule
